// File: rtl/ethernet_tx_pkg.sv
// Shared types and widths for the Ethernet transmit frame arbiter.
package ethernet_tx_pkg;
   localparam int AXIS_DATA_W = 64;
   localparam int AXIS_KEEP_W = 8;
   localparam int FRAME_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_GAP  = 2'd2
   } tx_state_e;
endpackage

// File: rtl/ethernet_rr_arbiter.sv
// Combinational rotating-priority pick: the first requester above the last
// winner (wrapping) gets a one-hot grant.
module ethernet_rr_arbiter #(
   parameter  int NUM_SRC = 3,
   localparam int SEL_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] i_req,
   input  logic [SEL_W-1:0]   i_last,
   output logic [NUM_SRC-1:0] o_grant,
   output logic               o_valid
);

   int  best_s;
   int  pick_s;
   int  raw_s;
   int  dist_s;
   logic take_s;

   // Distance from (last+1) mod NUM_SRC; the requester with the smallest distance wins.
   always_comb begin
      best_s  = NUM_SRC;
      pick_s  = 0;
      raw_s   = 0;
      dist_s  = 0;
      take_s  = 1'b0;
      o_grant = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         raw_s  = k - int'(i_last) - 1;
         dist_s = (raw_s < 0) ? raw_s + NUM_SRC : raw_s;
         take_s = i_req[k] && (dist_s < best_s);
         best_s = take_s ? dist_s : best_s;
         pick_s = take_s ? k : pick_s;
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         o_grant[k] = (|i_req) && (pick_s == k);
      end
   end

   assign o_valid = |i_req;

endmodule

// File: rtl/ethernet_tx_arbiter.sv
// Frame-level round-robin merge of NUM_SRC AXI-Stream transmit sources onto
// one registered MAC stream, with a programmable inter-frame idle gap.
module ethernet_tx_arbiter
   import ethernet_tx_pkg::*;
#(
   parameter int NUM_SRC    = 3,
   parameter int IFG_CYCLES = 1
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic [NUM_SRC-1:0]             s_axis_tvalid,
   input  logic [AXIS_DATA_W*NUM_SRC-1:0] s_axis_tdata,
   input  logic [AXIS_KEEP_W*NUM_SRC-1:0] s_axis_tkeep,
   input  logic [NUM_SRC-1:0]             s_axis_tlast,
   output logic [NUM_SRC-1:0]             s_axis_tready,
   output logic                           m_axis_tvalid,
   output logic [AXIS_DATA_W-1:0]         m_axis_tdata,
   output logic [AXIS_KEEP_W-1:0]         m_axis_tkeep,
   output logic                           m_axis_tlast,
   input  logic                           m_axis_tready,
   output logic [NUM_SRC-1:0]             o_grant,
   output logic                           o_busy,
   output logic [FRAME_CNT_W-1:0]         o_frame_count
);

   localparam int         SEL_W    = $clog2(NUM_SRC);
   localparam logic [3:0] GAP_LOAD = (IFG_CYCLES > 0) ? 4'(IFG_CYCLES - 1) : 4'd0;

   tx_state_e              state_q, state_d;
   logic [NUM_SRC-1:0]     grant_q, grant_d;
   logic [SEL_W-1:0]       last_q, last_d;
   logic [3:0]             gap_q, gap_d;
   logic                   m_valid_q, m_valid_d;
   logic [AXIS_DATA_W-1:0] m_data_q, m_data_d;
   logic [AXIS_KEEP_W-1:0] m_keep_q, m_keep_d;
   logic                   m_last_q, m_last_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   logic [NUM_SRC-1:0]     arb_grant_s;
   logic                   arb_valid_s;
   logic [SEL_W-1:0]       sel_s;
   logic                   src_valid_s;
   logic [AXIS_DATA_W-1:0] src_data_s;
   logic [AXIS_KEEP_W-1:0] src_keep_s;
   logic                   src_last_s;
   logic                   out_free_s;
   logic                   accept_s;

   ethernet_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
      .i_req   (s_axis_tvalid),
      .i_last  (last_q),
      .o_grant (arb_grant_s),
      .o_valid (arb_valid_s)
   );

   // Owner mux: grant_q is one-hot (or zero), so OR-ing the gated lanes selects the owner.
   always_comb begin
      sel_s       = '0;
      src_valid_s = 1'b0;
      src_data_s  = '0;
      src_keep_s  = '0;
      src_last_s  = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         sel_s       = sel_s       | (grant_q[k] ? SEL_W'(k) : '0);
         src_valid_s = src_valid_s | (grant_q[k] & s_axis_tvalid[k]);
         src_data_s  = src_data_s  | (grant_q[k] ? s_axis_tdata[k*AXIS_DATA_W +: AXIS_DATA_W] : '0);
         src_keep_s  = src_keep_s  | (grant_q[k] ? s_axis_tkeep[k*AXIS_KEEP_W +: AXIS_KEEP_W] : '0);
         src_last_s  = src_last_s  | (grant_q[k] & s_axis_tlast[k]);
      end
      out_free_s    = ~m_valid_q | m_axis_tready;
      s_axis_tready = (state_q == ST_XFER) ? (grant_q & {NUM_SRC{out_free_s}}) : '0;
      accept_s      = (state_q == ST_XFER) & src_valid_s & out_free_s;
   end

   // Frame state machine and gap counter next-state.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      gap_d   = gap_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid_s) begin
               grant_d = arb_grant_s;
               state_d = ST_XFER;
            end else begin
               grant_d = '0;
            end
         end
         ST_XFER: begin
            if (accept_s && src_last_s) begin
               last_d  = sel_s;
               grant_d = '0;
               if (IFG_CYCLES > 0) begin
                  state_d = ST_GAP;
                  gap_d   = GAP_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_XFER;
            end
         end
         ST_GAP: begin
            if (gap_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Output register: load on accept, drain when the MAC takes it, otherwise hold.
   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      m_last_d  = m_last_q;
      if (accept_s) begin
         m_valid_d = 1'b1;
         m_data_d  = src_data_s;
         m_keep_d  = src_keep_s;
         m_last_d  = src_last_s;
      end else if (m_axis_tready) begin
         m_valid_d = 1'b0;
      end else begin
         m_valid_d = m_valid_q;
      end
      frame_cnt_d = (m_valid_q & m_axis_tready & m_last_q) ?
                    frame_cnt_q + FRAME_CNT_W'(1) : frame_cnt_q;
   end

   // All state flops.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         last_q      <= SEL_W'(NUM_SRC - 1);
         gap_q       <= 4'd0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_keep_q    <= '0;
         m_last_q    <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         gap_q       <= gap_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_keep_q    <= m_keep_d;
         m_last_q    <= m_last_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tkeep  = m_keep_q;
   assign m_axis_tlast  = m_last_q;
   assign o_grant       = grant_q;
   assign o_busy        = (state_q != ST_IDLE);
   assign o_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// Directed bench for ethernet_tx_arbiter (NUM_SRC=3, IFG_CYCLES=1).
module tb_ethernet_tx_arbiter;
   localparam int NS = 3;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [NS-1:0] s_valid;
   logic [64*NS-1:0] s_data;
   logic [8*NS-1:0]  s_keep;
   logic [NS-1:0] s_last;
   logic [NS-1:0] s_ready;
   logic          m_valid;
   logic [63:0]   m_data;
   logic [7:0]    m_keep;
   logic          m_last;
   logic          m_ready;
   logic [NS-1:0] grant;
   logic          busy;
   logic [15:0]   fcount;

   always #5 clk = ~clk;

   ethernet_tx_arbiter #(.NUM_SRC(NS), .IFG_CYCLES(1)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .s_axis_tvalid (s_valid),
      .s_axis_tdata  (s_data),
      .s_axis_tkeep  (s_keep),
      .s_axis_tlast  (s_last),
      .s_axis_tready (s_ready),
      .m_axis_tvalid (m_valid),
      .m_axis_tdata  (m_data),
      .m_axis_tkeep  (m_keep),
      .m_axis_tlast  (m_last),
      .m_axis_tready (m_ready),
      .o_grant       (grant),
      .o_busy        (busy),
      .o_frame_count (fcount)
   );

   int    errors = 0;
   int    checks = 0;
   beat_t src_mem [NS][16];
   int    src_len [NS];
   int    src_ptr [NS];
   int    first_rdy [NS];
   int    tlast_cyc [NS];
   beat_t out_mem [64];
   int    out_cyc [64];
   int    out_cnt;
   int    cyc;

   function automatic logic [63:0] beat_data(input int src, input int tag, input int beat);
      return {16'hCAFE, 8'(src), 8'(tag), 24'h000000, 8'(beat)};
   endfunction

   function automatic beat_t exp_beat(input int src, input int tag, input int beat,
                                      input int nbeats, input logic [7:0] last_keep);
      beat_t b;
      b.d = beat_data(src, tag, beat);
      b.k = (beat == nbeats - 1) ? last_keep : 8'hFF;
      b.l = (beat == nbeats - 1);
      return b;
   endfunction

   task automatic load_frame(input int src, input int tag, input int nbeats, input logic [7:0] last_keep);
      for (int b = 0; b < nbeats; b++) begin
         if (src_len[src] < 16) begin
            src_mem[src][src_len[src]] = exp_beat(src, tag, b, nbeats, last_keep);
            src_len[src] = src_len[src] + 1;
         end
      end
   endtask

   task automatic clear_bench();
      for (int k = 0; k < NS; k++) begin
         src_len[k]   = 0;
         src_ptr[k]   = 0;
         first_rdy[k] = -1;
         tlast_cyc[k] = -1;
      end
      out_cnt = 0;
      cyc     = 0;
   endtask

   task automatic drive_idle();
      s_valid = '0;
      s_data  = '0;
      s_keep  = '0;
      s_last  = '0;
      m_ready = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_bench();
   endtask

   // Runs the source models for a number of cycles and records every output transfer.
   task automatic run(input int cycles, input logic [3:0] rdy_pat);
      logic [NS-1:0] acc;
      logic [1:0]    ph;
      for (int c = 0; c < cycles; c++) begin
         for (int k = 0; k < NS; k++) begin
            if (src_ptr[k] < src_len[k]) begin
               s_valid[k]          = 1'b1;
               s_data[k*64 +: 64]  = src_mem[k][src_ptr[k]].d;
               s_keep[k*8 +: 8]    = src_mem[k][src_ptr[k]].k;
               s_last[k]           = src_mem[k][src_ptr[k]].l;
            end else begin
               s_valid[k]          = 1'b0;
               s_data[k*64 +: 64]  = 64'h0;
               s_keep[k*8 +: 8]    = 8'h00;
               s_last[k]           = 1'b0;
            end
         end
         ph      = 2'(c);
         m_ready = rdy_pat[ph];
         #1;
         checks++;
         if ($countones(s_ready) > 1) begin
            errors++;
            $display("FAIL ready_onehot: cycle %0d got %b expected at most one bit", cyc, s_ready);
         end
         checks++;
         if ((s_ready != '0) && m_valid && !m_ready) begin
            errors++;
            $display("FAIL ready_when_full: cycle %0d got %b expected 000", cyc, s_ready);
         end
         acc = s_valid & s_ready;
         for (int k = 0; k < NS; k++) begin
            if (s_ready[k] && first_rdy[k] < 0) first_rdy[k] = cyc;
            if (acc[k] && s_last[k] && tlast_cyc[k] < 0) tlast_cyc[k] = cyc;
         end
         if (m_valid && m_ready && out_cnt < 64) begin
            out_mem[out_cnt] = '{d: m_data, k: m_keep, l: m_last};
            out_cyc[out_cnt] = cyc;
            out_cnt++;
         end
         @(posedge clk);
         #1;
         cyc++;
         for (int k = 0; k < NS; k++) begin
            if (acc[k]) src_ptr[k] = src_ptr[k] + 1;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      @(posedge clk);
      #1;
      checks++;
      if ({m_valid, m_data, m_keep, m_last} !== 74'h0) begin
         errors++;
         $display("FAIL reset_m_axis: got v=%b d=%h k=%h l=%b expected all 0", m_valid, m_data, m_keep, m_last);
      end
      checks++;
      if (s_ready !== 3'b000) begin
         errors++;
         $display("FAIL reset_s_ready: got %b expected 000", s_ready);
      end
      checks++;
      if (grant !== 3'b000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_grant_busy: got grant=%b busy=%b expected 000/0", grant, busy);
      end
      checks++;
      if (fcount !== 16'd0) begin
         errors++;
         $display("FAIL reset_fcount: got %0d expected 0", fcount);
      end
      rst = 1'b0;
      clear_bench();
   endtask

   task automatic test_single_frame();
      int exp_cyc [3] = '{2, 3, 4};
      do_reset();
      load_frame(0, 0, 3, 8'h0F);
      run(8, 4'b1111);
      checks++;
      if (out_cnt !== 3) begin
         errors++;
         $display("FAIL single_count: got %0d beats expected 3", out_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_mem[i] !== exp_beat(0, 0, i, 3, 8'h0F)) begin
            errors++;
            $display("FAIL single_beat%0d: got %h expected %h", i, out_mem[i], exp_beat(0, 0, i, 3, 8'h0F));
         end
         checks++;
         if (out_cyc[i] !== exp_cyc[i]) begin
            errors++;
            $display("FAIL single_cyc%0d: got %0d expected %0d", i, out_cyc[i], exp_cyc[i]);
         end
      end
      checks++;
      if (first_rdy[0] !== 1) begin
         errors++;
         $display("FAIL single_ready_latency: got %0d expected 1", first_rdy[0]);
      end
      checks++;
      if (fcount !== 16'd1 || busy !== 1'b0 || grant !== 3'b000) begin
         errors++;
         $display("FAIL single_end: got fcount=%0d busy=%b grant=%b expected 1/0/000", fcount, busy, grant);
      end
   endtask

   task automatic test_round_robin();
      int e_src [10] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1};
      int e_tag [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
      int e_cyc [10] = '{2, 3, 6, 7, 10, 11, 14, 15, 18, 19};
      do_reset();
      load_frame(0, 0, 2, 8'h03);
      load_frame(0, 1, 2, 8'h03);
      load_frame(1, 0, 2, 8'h03);
      load_frame(1, 1, 2, 8'h03);
      load_frame(2, 0, 2, 8'h03);
      run(24, 4'b1111);
      checks++;
      if (out_cnt !== 10) begin
         errors++;
         $display("FAIL rr_count: got %0d beats expected 10", out_cnt);
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out_mem[i] !== exp_beat(e_src[i], e_tag[i], i % 2, 2, 8'h03)) begin
            errors++;
            $display("FAIL rr_beat%0d: got %h expected %h", i, out_mem[i], exp_beat(e_src[i], e_tag[i], i % 2, 2, 8'h03));
         end
         checks++;
         if (out_cyc[i] !== e_cyc[i]) begin
            errors++;
            $display("FAIL rr_cyc%0d: got %0d expected %0d", i, out_cyc[i], e_cyc[i]);
         end
      end
      checks++;
      if (fcount !== 16'd5) begin
         errors++;
         $display("FAIL rr_fcount: got %0d expected 5", fcount);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      load_frame(0, 2, 4, 8'h01);
      run(20, 4'b0101);
      checks++;
      if (out_cnt !== 4 || src_ptr[0] !== 4) begin
         errors++;
         $display("FAIL bp_count: got out=%0d accepted=%0d expected 4/4", out_cnt, src_ptr[0]);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_mem[i] !== exp_beat(0, 2, i, 4, 8'h01)) begin
            errors++;
            $display("FAIL bp_beat%0d: got %h expected %h", i, out_mem[i], exp_beat(0, 2, i, 4, 8'h01));
         end
      end
      checks++;
      if (fcount !== 16'd1) begin
         errors++;
         $display("FAIL bp_fcount: got %0d expected 1", fcount);
      end
   endtask

   task automatic test_no_interleave();
      int e_src [6] = '{0, 0, 0, 0, 1, 1};
      int e_bt  [6] = '{0, 1, 2, 3, 0, 1};
      int e_n   [6] = '{4, 4, 4, 4, 2, 2};
      do_reset();
      load_frame(0, 3, 4, 8'hFF);
      load_frame(1, 3, 2, 8'h7F);
      run(16, 4'b1111);
      checks++;
      if (tlast_cyc[0] !== 4) begin
         errors++;
         $display("FAIL ni_src0_last: got cycle %0d expected 4", tlast_cyc[0]);
      end
      checks++;
      if (first_rdy[1] !== 7) begin
         errors++;
         $display("FAIL ni_src1_ready: got cycle %0d expected 7", first_rdy[1]);
      end
      checks++;
      if (out_cnt !== 6) begin
         errors++;
         $display("FAIL ni_count: got %0d beats expected 6", out_cnt);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (out_mem[i] !== exp_beat(e_src[i], 3, e_bt[i], e_n[i], (e_src[i] == 0) ? 8'hFF : 8'h7F)) begin
            errors++;
            $display("FAIL ni_beat%0d: got %h expected source %0d beat %0d", i, out_mem[i], e_src[i], e_bt[i]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      load_frame(0, 4, 4, 8'hFF);
      run(3, 4'b1111);
      checks++;
      if (m_valid !== 1'b1 || m_data !== beat_data(0, 4, 1)) begin
         errors++;
         $display("FAIL rmf_pre: got v=%b d=%h expected 1/%h", m_valid, m_data, beat_data(0, 4, 1));
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({m_valid, m_data, m_keep, m_last} !== 74'h0 || s_ready !== 3'b000) begin
         errors++;
         $display("FAIL rmf_outputs: got v=%b d=%h l=%b rdy=%b expected all 0", m_valid, m_data, m_last, s_ready);
      end
      checks++;
      if (grant !== 3'b000 || busy !== 1'b0 || fcount !== 16'd0) begin
         errors++;
         $display("FAIL rmf_state: got grant=%b busy=%b fcount=%0d expected 000/0/0", grant, busy, fcount);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_bench();
      load_frame(1, 5, 1, 8'h0F);
      load_frame(0, 5, 1, 8'h0F);
      run(10, 4'b1111);
      checks++;
      if (out_cnt !== 2) begin
         errors++;
         $display("FAIL rmf_count: got %0d beats expected 2", out_cnt);
      end
      checks++;
      if (out_mem[0].d !== beat_data(0, 5, 0) || out_mem[1].d !== beat_data(1, 5, 0)) begin
         errors++;
         $display("FAIL rmf_order: got %h,%h expected %h,%h", out_mem[0].d, out_mem[1].d, beat_data(0, 5, 0), beat_data(1, 5, 0));
      end
   endtask

   task automatic test_frame_count();
      int accepted;
      int budget;
      do_reset();
      accepted   = 0;
      budget     = 2000;
      s_valid[0] = 1'b1;
      s_data[63:0] = 64'h1234_5678_9ABC_DEF0;
      s_keep[7:0]  = 8'hFF;
      s_last[0]    = 1'b1;
      m_ready      = 1'b1;
      while (accepted < 300 && budget > 0) begin
         if (s_valid[0] && s_ready[0]) accepted++;
         @(posedge clk);
         #1;
         budget--;
      end
      s_valid[0] = 1'b0;
      checks++;
      if (accepted !== 300) begin
         errors++;
         $display("FAIL fc_timeout: got %0d frames accepted expected 300", accepted);
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (fcount !== 16'd300) begin
         errors++;
         $display("FAIL fc_value: got %0d expected 300", fcount);
      end
   endtask

   initial begin
      clear_bench();
      test_reset();
      test_single_frame();
      test_round_robin();
      test_backpressure();
      test_no_interleave();
      test_reset_mid_frame();
      test_frame_count();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
